ysyx_22040632_divider: RTL and testbench

Iterative radix-2 restoring integer divider for the RV64 M-extension datapath; the division counterpart to the Booth/Wallace-tree multiplier inside the execute-stage ALU extension. Accepts one DIV/DIVU/REM/REMU (64-bit) or DIVW/DIVUW/REMW/REMUW (32-bit) operation per valid/ready handshake, produces one quotient bit per cycle, and returns quotient and remainder together with a one-cycle result strobe. Supports pipeline flush mid-operation.

---
 rtl/ysyx_22040632_divider_if.sv | 25 ++
 rtl/ysyx_22040632_divider.sv | 165 ++++++++++++++++
 tb/tb_ysyx_22040632_divider.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040632_divider_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface ysyx_22040632_divider_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_valid;
  logic            divw;
  logic            div_signed;
  logic            flush;
  logic            div_ready;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output dividend, divisor, div_valid, divw, div_signed, flush,
    input  div_ready, out_valid, quotient, remainder
  );

  modport slave (
    input  dividend, divisor, div_valid, divw, div_signed, flush,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22040632_divider.sv
// Radix-2 restoring divider for RV64 DIV/REM and their W forms, one quotient bit per cycle.
// Define YSYX_22040632_DIV_EARLY_OUT_EN to skip iteration for zero divisors and |dividend| < |divisor|.
//
// state | meaning
// IDLE  | ready for a request, operands latched on accept
// CALC  | one shift/subtract step per cycle, counter runs N down to 0
// DONE  | result registers hold the answer, out_valid pulses
module ysyx_22040632_divider (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22040632_divider_if.slave   bus
);
  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [6:0]      cnt_q;
  logic            q_neg_q, r_neg_q, w_q, dvs_zero_q;
  logic [XLEN-1:0] quotient_q, remainder_q;

  logic [XLEN-1:0] dvd_ext, dvs_ext, dvd_mag, dvs_mag;
  logic            dvd_sign, dvs_sign, accept, early;

  logic [XLEN:0]   rem_trial;
  logic            trial_ge;
  logic [XLEN-1:0] rem_step, quo_step, res_q, res_r;

  // W operands are widened first so that one magnitude path serves both widths
  always_comb begin
    dvd_ext  = bus.divw ? {{32{bus.div_signed & bus.dividend[31]}}, bus.dividend[31:0]}
                        : bus.dividend;
    dvs_ext  = bus.divw ? {{32{bus.div_signed & bus.divisor[31]}}, bus.divisor[31:0]}
                        : bus.divisor;
    dvd_sign = bus.div_signed & dvd_ext[XLEN-1];
    dvs_sign = bus.div_signed & dvs_ext[XLEN-1];
    dvd_mag  = dvd_sign ? -dvd_ext : dvd_ext;
    dvs_mag  = dvs_sign ? -dvs_ext : dvs_ext;
  end

  assign accept = (state == IDLE) & bus.div_valid & ~bus.flush;

`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
  logic [XLEN-1:0] eo_rem;
  assign early  = (dvs_mag == '0) || (dvd_mag < dvs_mag);
  assign eo_rem = bus.divw ? {{32{bus.dividend[31]}}, bus.dividend[31:0]} : bus.dividend;
`else
  assign early  = 1'b0;
`endif

  always_comb begin
    rem_trial = {rem_q, quo_q[XLEN-1]};
    trial_ge  = rem_trial >= {1'b0, dvs_q};
    rem_step  = trial_ge ? XLEN'(rem_trial - {1'b0, dvs_q}) : rem_trial[XLEN-1:0];
    quo_step  = {quo_q[XLEN-2:0], trial_ge};
  end

  // A zero divisor leaves |dividend| in the remainder, so only the quotient needs a bypass
  always_comb begin
    res_q = q_neg_q ? -quo_step : quo_step;
    res_r = r_neg_q ? -rem_step : rem_step;
    if (w_q) begin
      res_q = {{32{res_q[31]}}, res_q[31:0]};
      res_r = {{32{res_r[31]}}, res_r[31:0]};
    end
    if (dvs_zero_q) begin
      res_q = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = early ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == 7'd1) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      w_q         <= 1'b0;
      dvs_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem_q      <= '0;
            quo_q      <= bus.divw ? {dvd_mag[31:0], 32'b0} : dvd_mag;
            dvs_q      <= dvs_mag;
            cnt_q      <= early ? 7'd0 : (bus.divw ? 7'd32 : 7'd64);
            q_neg_q    <= dvd_sign ^ dvs_sign;
            r_neg_q    <= dvd_sign;
            w_q        <= bus.divw;
            dvs_zero_q <= (dvs_mag == '0);
`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
            if (early) begin
              quotient_q  <= (dvs_mag == '0) ? '1 : '0;
              remainder_q <= eo_rem;
            end
`endif
          end
        end
        CALC: begin
          if (bus.flush) begin
            cnt_q <= '0;
          end else begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q == 7'd1) begin
              quotient_q  <= res_q;
              remainder_q <= res_r;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.div_ready = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
endmodule

// File: tb/tb_ysyx_22040632_divider.sv
// Scoreboard bench for the iterative divider: randomized and directed requests against an arithmetic model.
module tb_ysyx_22040632_divider;
`ifdef YSYX_22040632_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  ysyx_22040632_divider_if dif ();

  ysyx_22040632_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  logic ov_prev = 1'b0;

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // RISC-V M-extension semantics written directly in arithmetic terms
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s,
                                output logic [63:0] q, output logic [63:0] r, output bit eo);
    logic [31:0] a32, b32, q32, r32, am32, bm32;
    logic [63:0] am, bm;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      am32 = (s && a32[31]) ? -a32 : a32;
      bm32 = (s && b32[31]) ? -b32 : b32;
      eo   = (b32 == 32'd0) || (am32 < bm32);
      if (b32 == 32'd0) begin
        q32 = '1; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      am = (s && a[63]) ? -a : a;
      bm = (s && b[63]) ? -b : b;
      eo = (b == 64'd0) || (am < bm);
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
        q = a; r = 64'd0;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every out_valid pops one expectation; strays and overlong pulses are errors
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_out_valid at cycle %0d got 1 expected 0", cyc);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, " quotient"}, dif.quotient, mon_e.q);
          check({mon_e.name, " remainder"}, dif.remainder, mon_e.r);
          check({mon_e.name, " done_cycle"}, 64'(cyc), 64'(mon_e.due));
          check({mon_e.name, " ready_at_done"}, 64'(dif.div_ready), 64'd0);
        end
        if (ov_prev) begin
          n_vec++;
          n_err++;
          $display("FAIL out_valid_width got 2+ cycles expected 1");
        end
      end
      ov_prev = dif.out_valid;
    end else begin
      ov_prev = 1'b0;
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input bit w, input bit s,
                       input string name, output int unsigned acc);
    logic [63:0] q, r;
    bit          eo;
    int          k;
    exp_t        e;
    k = 0;
    @(negedge clk);
    while (!dif.div_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!dif.div_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL %s ready_timeout got 0 expected 1", name);
    end
    dif.dividend   = a;
    dif.divisor    = b;
    dif.divw       = w;
    dif.div_signed = s;
    dif.div_valid  = 1'b1;
    dif.flush      = 1'b0;
    model(a, b, w, s, q, r, eo);
    acc    = cyc;
    e.q    = q;
    e.r    = r;
    e.due  = cyc + ((EARLY && eo) ? 1 : (w ? 33 : 65));
    e.name = name;
    sb.push_back(e);
    @(negedge clk);
    dif.div_valid  = 1'b0;
    dif.dividend   = r64();
    dif.divisor    = r64();
    dif.divw       = ~w;
    dif.div_signed = ~s;
    check({name, " ready_after_accept"}, 64'(dif.div_ready), 64'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc;
    logic [63:0] a, b;
    bit          w, s;
    dif.dividend   = '0;
    dif.divisor    = '0;
    dif.div_valid  = 1'b0;
    dif.divw       = 1'b0;
    dif.div_signed = 1'b0;
    dif.flush      = 1'b0;
    #2;
    check("reset quotient", dif.quotient, 64'd0);
    check("reset remainder", dif.remainder, 64'd0);
    check("reset out_valid", 64'(dif.out_valid), 64'd0);
    check("reset div_ready", 64'(dif.div_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(64'd100, 64'd7, 1'b0, 1'b0, "divu_100_7", acc);
    drain();
    issue(-64'sd7, 64'd2, 1'b0, 1'b1, "div_m7_2", acc);
    issue(64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, "remw_ovf", acc);
    issue(64'd5, 64'd0, 1'b0, 1'b1, "div_5_0", acc);
    issue(64'hDEAD_BEEF_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, "divuw_by0", acc);
    issue(64'h8000_0000_0000_0000, '1, 1'b0, 1'b1, "div_ovf", acc);
    issue(64'd3, 64'd1000, 1'b0, 1'b0, "divu_small", acc);
    drain();

    // flush in CALC: abort at T+20, idle at T+21, nothing emitted
    issue(64'h8000_0000_0000_0000 | r64(), 64'd3, 1'b0, 1'b0, "flushed_op", acc);
    while (cyc < acc + 20) @(negedge clk);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    check("flush ready_at_T21", 64'(dif.div_ready), 64'd1);
    void'(sb.pop_back());
    repeat (80) @(negedge clk);
    issue(64'd9, 64'd3, 1'b0, 1'b0, "divu_9_3", acc);
    drain();

    // flush together with a request in IDLE must not accept it
    @(negedge clk);
    dif.div_valid = 1'b1;
    dif.flush     = 1'b1;
    @(negedge clk);
    dif.div_valid = 1'b0;
    dif.flush     = 1'b0;
    check("flush_valid no_accept", 64'(dif.div_ready), 64'd1);
    repeat (70) @(negedge clk);

    // asynchronous reset mid-operation
    issue(r64(), 64'd7, 1'b0, 1'b0, "reset_op", acc);
    while (cyc < acc + 10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_reset quotient", dif.quotient, 64'd0);
    check("midop_reset remainder", dif.remainder, 64'd0);
    check("midop_reset out_valid", 64'(dif.out_valid), 64'd0);
    check("midop_reset div_ready", 64'(dif.div_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (70) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = r64();
      b = r64() >> $urandom_range(0, 63);
      case ($urandom_range(0, 7))
        0: b = w ? {r64() & 64'hFFFF_FFFF_0000_0000} : 64'd0;
        1: begin
          a = w ? {r64() & 64'hFFFF_FFFF_0000_0000} | 64'h8000_0000 : 64'h8000_0000_0000_0000;
          b = '1;
        end
        2: a = 64'($urandom_range(0, 15));
        default: ;
      endcase
      issue(a, b, w, s, $sformatf("rand%0d", i), acc);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
